// File: rtl/led_sequence_decoder.sv
// On-line decoder/checker for the bound_flasher LED bus: tracks the thermometer level,
// ramp direction and reversals, and raises sticky protocol-violation flags.
module led_sequence_decoder #(
  parameter int WIDTH     = 16,
  parameter int STALL_MAX = 64,
  parameter int CNT_W     = 8,
  localparam int LW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_state,
  input  logic             clr_err,
  output logic [LW-1:0]    level,
  output logic [1:0]       dir,
  output logic             turn_pulse,
  output logic [LW-1:0]    turn_level,
  output logic [CNT_W-1:0] turn_cnt,
  output logic             seq_done,
  output logic             err_code,
  output logic             err_step,
  output logic             err_stall
);

  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  state_t        state;
  logic [SW-1:0] stall_cnt;
  logic [LW-1:0] n;
  logic          valid;
  logic          same;
  logic          up1;
  logic          dn1;

  // A thermometer code 2^k-1 has no carry-free overlap with itself plus one.
  always_comb begin
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + LW'(led_state[i]);
    end
    valid = ((led_state & (led_state + 1'b1)) == '0);
    same  = (n == level);
    up1   = ({1'b0, n} == ({1'b0, level} + 1'b1));
    dn1   = (({1'b0, n} + 1'b1) == {1'b0, level});
  end

  assign dir = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      level      <= '0;
      turn_pulse <= 1'b0;
      turn_level <= '0;
      turn_cnt   <= '0;
      seq_done   <= 1'b0;
      err_code   <= 1'b0;
      err_step   <= 1'b0;
      err_stall  <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      turn_pulse <= 1'b0;
      seq_done   <= 1'b0;
      // Clear first so that an error detected on this same edge wins.
      if (clr_err) begin
        err_code  <= 1'b0;
        err_step  <= 1'b0;
        err_stall <= 1'b0;
      end
      if (!valid) begin
        err_code  <= 1'b1;
        stall_cnt <= '0;
      end else begin
        level <= n;
        if (state == IDLE) begin
          stall_cnt <= '0;
          if (n != '0) state <= UP;
          if (!same && !up1) err_step <= 1'b1;
        end else if (same) begin
          if (stall_cnt != STALL_LIM) stall_cnt <= stall_cnt + 1'b1;
          if (stall_cnt >= STALL_LIM - 1'b1) err_stall <= 1'b1;
        end else if (!up1 && !dn1) begin
          err_step  <= 1'b1;
          stall_cnt <= '0;
          if (n == '0) begin
            state    <= IDLE;
            seq_done <= 1'b1;
            turn_cnt <= '0;
          end
        end else begin
          stall_cnt <= '0;
          if ((state == UP && dn1) || (state == DOWN && up1)) begin
            state      <= (state == UP) ? DOWN : UP;
            turn_pulse <= 1'b1;
            turn_level <= level;
            if (!(&turn_cnt)) turn_cnt <= turn_cnt + 1'b1;
          end else if (state == DOWN && n == '0) begin
            state    <= IDLE;
            seq_done <= 1'b1;
            turn_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_sequence_decoder.sv
// Directed self-checking bench for led_sequence_decoder at default parameters.
module tb_led_sequence_decoder;

  logic        clk;
  logic        rst;
  logic [15:0] led_state;
  logic        clr_err;
  logic [4:0]  level;
  logic [1:0]  dir;
  logic        turn_pulse;
  logic [4:0]  turn_level;
  logic [7:0]  turn_cnt;
  logic        seq_done;
  logic        err_code;
  logic        err_step;
  logic        err_stall;

  int checks = 0;
  int errors = 0;

  led_sequence_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .led_state  (led_state),
    .clr_err    (clr_err),
    .level      (level),
    .dir        (dir),
    .turn_pulse (turn_pulse),
    .turn_level (turn_level),
    .turn_cnt   (turn_cnt),
    .seq_done   (seq_done),
    .err_code   (err_code),
    .err_step   (err_step),
    .err_stall  (err_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] therm(input int k);
    logic [31:0] t;
    t = (32'h1 << k) - 32'h1;
    return t[15:0];
  endfunction

  task automatic apply_stimulus(input logic [15:0] v, input logic c);
    led_state = v;
    clr_err   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    assert (actual === expected) else begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", tag, actual, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  task automatic check_flags(input string tag, input logic ec, input logic es,
                             input logic st);
    check_output({tag, ".err_code"}, 32'(err_code), 32'(ec));
    check_output({tag, ".err_step"}, 32'(err_step), 32'(es));
    check_output({tag, ".err_stall"}, 32'(err_stall), 32'(st));
  endtask

  initial begin
    int exp_cnt;
    rst       = 1'b1;
    led_state = 16'hFFFF;
    clr_err   = 1'b0;
    repeat (3) apply_stimulus(16'hFFFF, 1'b0);
    check_output("rst.level", 32'(level), 0);
    check_output("rst.dir", 32'(dir), 0);
    check_output("rst.turn_pulse", 32'(turn_pulse), 0);
    check_output("rst.seq_done", 32'(seq_done), 0);
    check_output("rst.turn_cnt", 32'(turn_cnt), 0);
    check_output("rst.turn_level", 32'(turn_level), 0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);

    rst = 1'b0;
    apply_stimulus(16'h0000, 1'b0);
    check_output("idle.dir", 32'(dir), 0);
    check_output("idle.level", 32'(level), 0);

    // Full flasher sequence 0->16->5->10->0
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(therm(i), 1'b0);
      check_output("seq.up1.level", 32'(level), 32'(i));
      check_output("seq.up1.dir", 32'(dir), 1);
      check_output("seq.up1.pulse", 32'(turn_pulse), 0);
    end
    for (int i = 15; i >= 5; i--) begin
      apply_stimulus(therm(i), 1'b0);
      check_output("seq.dn1.level", 32'(level), 32'(i));
      check_output("seq.dn1.dir", 32'(dir), 2);
      check_output("seq.dn1.pulse", 32'(turn_pulse), 32'(i == 15));
      if (i == 15) check_output("seq.turn16", 32'(turn_level), 16);
    end
    for (int i = 6; i <= 10; i++) begin
      apply_stimulus(therm(i), 1'b0);
      check_output("seq.up2.dir", 32'(dir), 1);
      check_output("seq.up2.pulse", 32'(turn_pulse), 32'(i == 6));
      if (i == 6) check_output("seq.turn5", 32'(turn_level), 5);
    end
    for (int i = 9; i >= 1; i--) begin
      apply_stimulus(therm(i), 1'b0);
      check_output("seq.dn2.dir", 32'(dir), 2);
      check_output("seq.dn2.pulse", 32'(turn_pulse), 32'(i == 9));
      check_output("seq.dn2.done", 32'(seq_done), 0);
      if (i == 9) check_output("seq.turn10", 32'(turn_level), 10);
    end
    check_output("seq.cnt3", 32'(turn_cnt), 3);
    apply_stimulus(16'h0000, 1'b0);
    check_output("seq.done", 32'(seq_done), 1);
    check_output("seq.end.dir", 32'(dir), 0);
    check_output("seq.end.cnt", 32'(turn_cnt), 0);
    check_output("seq.end.pulse", 32'(turn_pulse), 0);
    apply_stimulus(16'h0000, 1'b0);
    check_output("seq.done_off", 32'(seq_done), 0);
    check_flags("seq", 1'b0, 1'b0, 1'b0);

    // Step error 3 -> 6
    for (int i = 1; i <= 3; i++) apply_stimulus(therm(i), 1'b0);
    apply_stimulus(16'h003F, 1'b0);
    check_output("step.level", 32'(level), 6);
    check_output("step.dir", 32'(dir), 1);
    check_flags("step", 1'b0, 1'b1, 1'b0);
    apply_stimulus(16'h003F, 1'b1);
    check_flags("step.clr", 1'b0, 1'b0, 1'b0);

    // Invalid code at level 3
    for (int i = 5; i >= 3; i--) apply_stimulus(therm(i), 1'b0);
    check_output("inv.pre.level", 32'(level), 3);
    apply_stimulus(16'h0005, 1'b0);
    check_output("inv.level", 32'(level), 3);
    check_output("inv.dir", 32'(dir), 2);
    check_flags("inv", 1'b1, 1'b0, 1'b0);
    apply_stimulus(16'h000F, 1'b0);
    check_output("inv.next.level", 32'(level), 4);
    check_output("inv.next.pulse", 32'(turn_pulse), 1);
    check_output("inv.next.tlevel", 32'(turn_level), 3);
    check_flags("inv.next", 1'b1, 1'b0, 1'b0);
    apply_stimulus(16'h000F, 1'b1);
    check_flags("inv.clr", 1'b0, 1'b0, 1'b0);

    // Stall at level 8
    for (int i = 5; i <= 8; i++) apply_stimulus(therm(i), 1'b0);
    for (int k = 1; k <= 64; k++) begin
      apply_stimulus(16'h00FF, 1'b0);
      check_output("stall.flag", 32'(err_stall), 32'(k == 64));
    end
    apply_stimulus(16'h00FF, 1'b1);
    check_output("stall.clr_hold", 32'(err_stall), 1);
    apply_stimulus(16'h01FF, 1'b1);
    check_output("stall.clr", 32'(err_stall), 0);
    check_output("stall.level", 32'(level), 9);

    // Kickback valley and turn counter saturation
    for (int i = 8; i >= 5; i--) apply_stimulus(therm(i), 1'b0);
    check_output("kick.cnt3", 32'(turn_cnt), 3);
    apply_stimulus(16'h003F, 1'b0);
    check_output("kick.pulse", 32'(turn_pulse), 1);
    check_output("kick.tlevel", 32'(turn_level), 5);
    check_output("kick.dir", 32'(dir), 1);
    check_output("kick.cnt4", 32'(turn_cnt), 4);
    for (int i = 1; i <= 300; i++) begin
      apply_stimulus((i % 2 == 1) ? 16'h001F : 16'h003F, 1'b0);
      exp_cnt = (4 + i > 255) ? 255 : 4 + i;
      check_output("sat.cnt", 32'(turn_cnt), 32'(exp_cnt));
      check_output("sat.pulse", 32'(turn_pulse), 1);
      check_output("sat.tlevel", 32'(turn_level), (i % 2 == 1) ? 6 : 5);
    end
    for (int i = 5; i >= 1; i--) apply_stimulus(therm(i), 1'b0);
    check_output("sat.hold", 32'(turn_cnt), 255);
    apply_stimulus(16'h0000, 1'b0);
    check_output("sat.done", 32'(seq_done), 1);
    check_output("sat.cnt0", 32'(turn_cnt), 0);
    check_flags("end", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
